expr_eval: RTL and testbench
============================

EXPR_EVAL -- requirements
Module: expr_eval

Interface
REQ-001 clk  input  1  Single clock; all state updates on rising edge.
REQ-002 clr_n  input  1  Reset, asynchronous assert, active-low; clears all state and outputs.
REQ-003 in  input  8  ASCII character sampled every rising edge: '0'-'9' (48-57) digit, '+' (43), '*' (42), 8'h00 idle, anything else illegal.
REQ-004 ok  output  1  1 = characters accepted since reset form a complete valid expression.
REQ-005 err  output  1  Sticky 1 once an illegal character or illegal sequence is seen.
REQ-006 result  output  16  Value of the expression evaluated so far, with '*' binding tighter than '+'.
REQ-007 ovf  output  1  Sticky arithmetic overflow flag; meaningful only with EXPR_SAT_EN.

Function
REQ-008 The block SHALL be the evaluation stage downstream of the expression recogniser: it consumes the same one-char-per-cycle stream and produces the value.
REQ-009 Operands SHALL be single decimal digits; two consecutive digits SHALL be a sequence error.
REQ-010 FSM states SHALL be IDLE (nothing accepted), NUM (last char digit), OP (last char operator), ERR.
REQ-011 Transitions SHALL be: IDLE+digit->NUM; NUM+op->OP; OP+digit->NUM; any other non-idle char in IDLE/NUM/OP ->ERR; ERR stays ERR until reset.
REQ-012 in==8'h00 SHALL hold state, registers and outputs unchanged in every state.
REQ-013 Internal registers: sum[15:0], term[15:0], pending-op bit (add/mul).
REQ-014 Digit d in IDLE SHALL set term=d, sum=0.
REQ-015 Digit d in OP after '+' SHALL set term=d; after '*' SHALL set term=term*d.
REQ-016 '+' in NUM SHALL set sum=sum+term, term=0, pending-op=add; '*' in NUM SHALL keep term, set pending-op=mul.
REQ-017 result SHALL be registered and equal next sum+next term after each accepted digit; it SHALL hold its value across operators, idle cycles and entry to ERR.
REQ-018 ok SHALL be registered, 1 exactly when the state after the edge is NUM.
REQ-019 err SHALL be 1 exactly when the state after the edge is ERR; ok SHALL then be 0.
REQ-020 Latency: outputs SHALL reflect the character sampled at an edge immediately after that edge (one-cycle registered).
REQ-021 Arithmetic SHALL be unsigned; products and sums wider than 16 bits SHALL be handled per REQ-026/027.

Reset
REQ-022 clr_n low SHALL asynchronously force state=IDLE, sum=0, term=0, pending-op=add, result=0, ok=0, err=0, ovf=0.
REQ-023 Reset asserted mid-expression SHALL discard all partial state; the first character after release SHALL be treated as the start of a new expression.
REQ-024 A character present on the first rising edge after clr_n rises SHALL be sampled normally.
REQ-025 There SHALL be no other way to leave ERR than reset.

Configuration
REQ-026 Without macro EXPR_SAT_EN, sums and products SHALL wrap modulo 2^16 and ovf SHALL be tied 0.
REQ-027 With EXPR_SAT_EN defined, any product or sum exceeding 16'hFFFF SHALL saturate to 16'hFFFF and set ovf sticky until reset; ok/err behaviour SHALL be unchanged.

Verification
REQ-028 Reset, then "2*3+4" on 5 edges -> after edge 5: ok=1, result=10, err=0; after '+' edge: ok=0, result=6.
REQ-029 Reset, then "0*1+" -> after last edge: ok=0, err=0, result=0; then "1" -> ok=1, result=1.
REQ-030 Reset, then "1","1" -> err=1, ok=0, result=1; further "+2" leaves err=1, result=1.
REQ-031 Reset, "3",8'h00,8'h00,"+","4" -> result=7, ok=1; idle cycles leave outputs unchanged.
REQ-032 "9*9*9*9*9*9" -> result=7153, ovf=0 without EXPR_SAT_EN; result=16'hFFFF, ovf=1 with it.
REQ-033 "5*" then clr_n low for one cycle mid-stream -> all outputs 0 asynchronously; then "7" -> ok=1, result=7.

Source files
------------

// File: rtl/expr_eval_if.sv
// Character stream in, evaluation status and value out, for the expression evaluator.
interface expr_eval_if;
  logic [7:0]  in;
  logic        ok;
  logic        err;
  logic [15:0] result;
  logic        ovf;

  modport master (output in, input ok, err, result, ovf);
  modport slave  (input in, output ok, err, result, ovf);
endinterface

// File: rtl/expr_eval.sv
// Evaluates a one-character-per-cycle stream of digits, '+' and '*' with '*' binding tighter.
// Define EXPR_SAT_EN to saturate arithmetic at 16'hFFFF and raise sticky ovf; default wraps mod 2^16.
module expr_eval (
  input  logic             clk,
  input  logic             clr_n,
  expr_eval_if.slave       bus,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NUM  = 2'd1,
    OP   = 2'd2,
    ERR  = 2'd3
  } state_t;

`ifdef EXPR_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [15:0] sum_q, sum_d;
  logic [15:0] term_q, term_d;
  logic [15:0] result_q, result_d;
  logic        mul_q, mul_d;
  logic        ovf_q, ovf_d;

  logic        is_digit, is_plus, is_star, is_idle;
  logic [3:0]  dig;
  logic [31:0] prod_w;
  logic [16:0] fit_t, fit_r;

  // Returns {overflowed, value}; overflow is only reported when saturating.
  function automatic logic [16:0] fit(input logic [31:0] v);
    logic over;
    over = |v[31:16];
    if (SAT_EN && over) return {1'b1, 16'hFFFF};
    return {1'b0, v[15:0]};
  endfunction

  assign is_digit = (bus.in >= 8'd48) && (bus.in <= 8'd57);
  assign is_plus  = (bus.in == 8'd43);
  assign is_star  = (bus.in == 8'd42);
  assign is_idle  = (bus.in == 8'h00);
  assign dig      = bus.in[3:0];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (is_digit) state_d = NUM;
            else if (!is_idle) state_d = ERR;
      NUM:  if (is_plus || is_star) state_d = OP;
            else if (!is_idle) state_d = ERR;
      OP:   if (is_digit) state_d = NUM;
            else if (!is_idle) state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_comb begin
    bus.ok     = (state_q == NUM);
    bus.err    = (state_q == ERR);
    bus.result = result_q;
    bus.ovf    = ovf_q;
    state_o    = state_q;
  end

  // Only accepted characters touch the datapath; idle and ERR leave every register alone.
  always_comb begin
    sum_d    = sum_q;
    term_d   = term_q;
    mul_d    = mul_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    prod_w   = {16'b0, term_q} * {28'b0, dig};
    fit_t    = 17'b0;
    fit_r    = 17'b0;
    case (state_q)
      IDLE: begin
        if (is_digit) begin
          sum_d    = 16'b0;
          term_d   = {12'b0, dig};
          result_d = {12'b0, dig};
        end
      end
      NUM: begin
        if (is_plus) begin
          fit_r  = fit({16'b0, sum_q} + {16'b0, term_q});
          sum_d  = fit_r[15:0];
          ovf_d  = ovf_q | fit_r[16];
          term_d = 16'b0;
          mul_d  = 1'b0;
        end else if (is_star) begin
          mul_d  = 1'b1;
        end
      end
      OP: begin
        if (is_digit) begin
          fit_t    = fit(mul_q ? prod_w : {28'b0, dig});
          term_d   = fit_t[15:0];
          fit_r    = fit({16'b0, sum_q} + {16'b0, fit_t[15:0]});
          result_d = fit_r[15:0];
          ovf_d    = ovf_q | fit_t[16] | fit_r[16];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sum_q    <= 16'b0;
      term_q   <= 16'b0;
      mul_q    <= 1'b0;
      result_q <= 16'b0;
      ovf_q    <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      term_q   <= term_d;
      mul_q    <= mul_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_expr_eval.sv
// Directed bench for expr_eval: each step pushes the expected {state,ok,err,ovf,result} and checks it after the edge.
module tb_expr_eval;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NUM  = 2'd1;
  localparam logic [1:0] S_OP   = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

`ifdef EXPR_SAT_EN
  localparam logic [15:0] BIG_RES = 16'hFFFF;
  localparam logic        BIG_OVF = 1'b1;
`else
  localparam logic [15:0] BIG_RES = 16'd7153;
  localparam logic        BIG_OVF = 1'b0;
`endif

  logic       clk;
  logic       clr_n;
  logic [1:0] state_o;
  int         n_checks;
  int         n_fail;
  logic [20:0] exp_q[$];

  expr_eval_if bus ();

  expr_eval dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_out(input string tag);
    logic [20:0] exp_v;
    logic [20:0] obs_v;
    obs_v = {state_o, bus.ok, bus.err, bus.ovf, bus.result};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard empty observed=%h", tag, obs_v);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs_v === exp_v) else begin
        n_fail++;
        $error("FAIL %s observed st/ok/err/ovf/res=%h expected=%h", tag, obs_v, exp_v);
      end
    end
  endtask

  task automatic send(input logic [7:0] c, input logic [1:0] st, input logic ok,
                      input logic err, input logic ovf, input logic [15:0] res, input string tag);
    @(negedge clk);
    bus.in = c;
    exp_q.push_back({st, ok, err, ovf, res});
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    bus.in = 8'h00;
    clr_n  = 1'b0;
    @(negedge clk);
    #1;
    exp_q.push_back({S_IDLE, 1'b0, 1'b0, 1'b0, 16'd0});
    check_out(tag);
    @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr_n    = 1'b0;
    bus.in   = 8'h00;

    do_reset("reset0");
    send("2", S_NUM, 1, 0, 0, 16'd2,  "a_2");
    send("*", S_OP,  0, 0, 0, 16'd2,  "a_mul");
    send("3", S_NUM, 1, 0, 0, 16'd6,  "a_3");
    send("+", S_OP,  0, 0, 0, 16'd6,  "a_plus");
    send("4", S_NUM, 1, 0, 0, 16'd10, "a_4");

    do_reset("reset1");
    send("0", S_NUM, 1, 0, 0, 16'd0, "b_0");
    send("*", S_OP,  0, 0, 0, 16'd0, "b_mul");
    send("1", S_NUM, 1, 0, 0, 16'd0, "b_1");
    send("+", S_OP,  0, 0, 0, 16'd0, "b_plus");
    send("1", S_NUM, 1, 0, 0, 16'd1, "b_1b");

    do_reset("reset2");
    send("1", S_NUM, 1, 0, 0, 16'd1, "c_1");
    send("1", S_ERR, 0, 1, 0, 16'd1, "c_dd_err");
    send("+", S_ERR, 0, 1, 0, 16'd1, "c_err_plus");
    send("2", S_ERR, 0, 1, 0, 16'd1, "c_err_2");
    send(8'h00, S_ERR, 0, 1, 0, 16'd1, "c_err_idle");

    do_reset("reset3");
    send(8'h00, S_IDLE, 0, 0, 0, 16'd0, "d_idle_idle");
    send("3",   S_NUM,  1, 0, 0, 16'd3, "d_3");
    send(8'h00, S_NUM,  1, 0, 0, 16'd3, "d_idle1");
    send(8'h00, S_NUM,  1, 0, 0, 16'd3, "d_idle2");
    send("+",   S_OP,   0, 0, 0, 16'd3, "d_plus");
    send(8'h00, S_OP,   0, 0, 0, 16'd3, "d_idle_op");
    send("4",   S_NUM,  1, 0, 0, 16'd7, "d_4");

    do_reset("reset4");
    send("+", S_ERR, 0, 1, 0, 16'd0, "e_op_first");
    do_reset("reset5");
    send("7", S_NUM, 1, 0, 0, 16'd7, "e_7");
    send("A", S_ERR, 0, 1, 0, 16'd7, "e_illegal");
    do_reset("reset6");
    send("1", S_NUM, 1, 0, 0, 16'd1, "e_1");
    send("*", S_OP,  0, 0, 0, 16'd1, "e_mul");
    send("*", S_ERR, 0, 1, 0, 16'd1, "e_op_op");

    do_reset("reset7");
    send("9", S_NUM, 1, 0, 0, 16'd9,     "f_9a");
    send("*", S_OP,  0, 0, 0, 16'd9,     "f_m1");
    send("9", S_NUM, 1, 0, 0, 16'd81,    "f_9b");
    send("*", S_OP,  0, 0, 0, 16'd81,    "f_m2");
    send("9", S_NUM, 1, 0, 0, 16'd729,   "f_9c");
    send("*", S_OP,  0, 0, 0, 16'd729,   "f_m3");
    send("9", S_NUM, 1, 0, 0, 16'd6561,  "f_9d");
    send("*", S_OP,  0, 0, 0, 16'd6561,  "f_m4");
    send("9", S_NUM, 1, 0, 0, 16'd59049, "f_9e");
    send("*", S_OP,  0, 0, 0, 16'd59049, "f_m5");
    send("9", S_NUM, 1, 0, BIG_OVF, BIG_RES, "f_9f");
    send("+", S_OP,  0, 0, BIG_OVF, BIG_RES, "f_ovf_sticky");

    do_reset("reset8");
    send("5", S_NUM, 1, 0, 0, 16'd5, "g_5");
    send("*", S_OP,  0, 0, 0, 16'd5, "g_mul");
    @(negedge clk);
    bus.in = 8'h00;
    #2;
    clr_n = 1'b0;
    #1;
    exp_q.push_back({S_IDLE, 1'b0, 1'b0, 1'b0, 16'd0});
    check_out("g_async_clear");
    @(negedge clk);
    clr_n = 1'b1;
    send("7", S_NUM, 1, 0, 0, 16'd7, "g_7_after");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL leftover scoreboard entries observed=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
